// File: rtl/ram_bus_arbiter2.sv
// Two-master round-robin arbiter in front of one RAM port: zero-latency forwarding of the
// granted master, with read responses steered back through an in-order ID FIFO.
module ram_bus_arbiter2 #(
   parameter int RESP_DEPTH = 2,
   parameter int FIFO_AW    = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_bi,
   input  logic [3:0]  m0_be_bi,
   input  logic [31:0] m0_wdata_bi,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_bo,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_bi,
   input  logic [3:0]  m1_be_bi,
   input  logic [31:0] m1_wdata_bi,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_bo,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_bo,
   output logic [3:0]  s_be_bo,
   output logic [31:0] s_wdata_bo,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_bi
);

   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(RESP_DEPTH);

   logic [1:0]         req_vec;
   logic [1:0]         ack_vec;
   logic [1:0]         resp_vec;
   logic               rr_last_reg;
   logic               lock_vld_reg;
   logic               lock_id_reg;
   logic               fifo_mem [RESP_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               grant;
   logic               head;
   logic               blocked;
   logic               accept;
   logic               push;
   logic               pop;

   assign req_vec = {m1_req_i, m0_req_i};

   always_comb begin
      grant = 1'b0;
      if (lock_vld_reg) begin
         grant = lock_id_reg;
      end else if (req_vec == 2'b10) begin
         grant = 1'b1;
      end else if (req_vec == 2'b11) begin
         grant = ~rr_last_reg;
      end
   end

   assign s_we_o     = grant ? m1_we_i     : m0_we_i;
   assign s_addr_bo  = grant ? m1_addr_bi  : m0_addr_bi;
   assign s_be_bo    = grant ? m1_be_bi    : m0_be_bi;
   assign s_wdata_bo = grant ? m1_wdata_bi : m0_wdata_bi;

   // A response arriving this cycle frees a slot, so a full FIFO still admits a read.
   assign head    = fifo_mem[rd_ptr_reg];
   assign pop     = s_resp_i && (count_reg != '0);
   assign blocked = !s_we_o && (count_reg == DEPTH_C) && !s_resp_i;
   assign s_req_o = req_vec[grant] && !blocked;
   assign accept  = s_req_o && s_ack_i;
   assign push    = accept && !s_we_o;

   for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign ack_vec[gi]  = accept && (grant == 1'(gi));
      assign resp_vec[gi] = pop && (head == 1'(gi));
   end

   assign m0_ack_o    = ack_vec[0];
   assign m1_ack_o    = ack_vec[1];
   assign m0_resp_o   = resp_vec[0];
   assign m1_resp_o   = resp_vec[1];
   assign m0_rdata_bo = s_rdata_bi;
   assign m1_rdata_bo = s_rdata_bi;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_last_reg  <= 1'b1;
         lock_vld_reg <= 1'b0;
         lock_id_reg  <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         // Hold the grant across a stalled request so the slave never sees a switch.
         if (accept) begin
            rr_last_reg  <= grant;
            lock_vld_reg <= 1'b0;
         end else if (s_req_o) begin
            lock_vld_reg <= 1'b1;
            lock_id_reg  <= grant;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= grant;
      end
   end

endmodule

// File: tb/tb_ram_bus_arbiter2.sv
// Bench for ram_bus_arbiter2: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the arbitration and response-routing rules.
module tb_ram_bus_arbiter2;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr [2];
   logic [3:0]  be [2];
   logic [31:0] wdata [2];
   logic        s_ack;
   logic        s_resp;
   logic [31:0] s_rdata;
   logic        m0_ack, m1_ack, m0_resp, m1_resp;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_req, s_we;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_be;

   always #5 clk = ~clk;

   ram_bus_arbiter2 #(.RESP_DEPTH(DEPTH), .FIFO_AW(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_bi(addr[0]), .m0_be_bi(be[0]),
      .m0_wdata_bi(wdata[0]), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
      .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_bi(addr[1]), .m1_be_bi(be[1]),
      .m1_wdata_bi(wdata[1]), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
      .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
      .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state: last served master, held grant (-1 = none), outstanding read IDs.
   int m_rr;
   int m_lock;
   int m_q [$];
   int e_g;
   int e_id;
   bit e_sreq, e_ack, e_pop, e_rd;
   bit pend [2];

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input string tag);
      logic [4:0] ctrl_exp;
      #1;
      if (m_lock >= 0)                 e_g = m_lock;
      else if (req[0] && !req[1])      e_g = 0;
      else if (req[1] && !req[0])      e_g = 1;
      else if (req[0] && req[1])       e_g = 1 - m_rr;
      else                             e_g = 0;
      e_rd   = !we[e_g];
      e_sreq = req[e_g] && (!e_rd || m_q.size() < DEPTH || s_resp);
      e_ack  = e_sreq && s_ack;
      e_pop  = s_resp && (m_q.size() > 0);
      e_id   = e_pop ? m_q[0] : 0;
      ctrl_exp = {e_ack && e_g == 0, e_ack && e_g == 1,
                  e_pop && e_id == 0, e_pop && e_id == 1, e_sreq};
      chk({tag, "_ctrl"}, 72'({m0_ack, m1_ack, m0_resp, m1_resp, s_req}), 72'(ctrl_exp));
      chk({tag, "_mux"}, 72'({s_we, s_addr, s_be, s_wdata}),
          72'({we[e_g], addr[e_g], be[e_g], wdata[e_g]}));
      chk({tag, "_rdata"}, 72'({m0_rdata, m1_rdata}), 72'({s_rdata, s_rdata}));
   endtask

   task automatic advance();
      @(posedge clk);
      if (e_pop) void'(m_q.pop_front());
      if (e_ack) begin
         m_rr   = e_g;
         m_lock = -1;
         if (e_rd) m_q.push_back(e_g);
         pend[e_g] = 1'b0;
      end else if (e_sreq) begin
         m_lock = e_g;
      end
      @(negedge clk);
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      @(posedge clk);
      m_rr   = 1;
      m_lock = -1;
      m_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req = '0; we = '0; s_ack = 1'b1; s_resp = 1'b0; s_rdata = '0;
      for (int m = 0; m < 2; m++) begin
         addr[m] = '0; be[m] = 4'hF; wdata[m] = '0; pend[m] = 1'b0;
      end
      reset_cycle();

      check_cycle("idle");
      chk("reset_idle", 72'({m0_ack, m1_ack, m0_resp, m1_resp, s_req}), 72'(0));
      advance();

      // 1: single read from m0, response one cycle later
      req = 2'b01; we[0] = 1'b0; addr[0] = 32'h10;
      check_cycle("t1a");
      chk("t1_ack", 72'(m0_ack), 72'(1));
      chk("t1_addr", 72'(s_addr), 72'(32'h10));
      advance();
      req = 2'b00; s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
      check_cycle("t1b");
      chk("t1_resp", 72'({m0_resp, m1_resp}), 72'(2'b10));
      chk("t1_rdata", 72'(m0_rdata), 72'(32'hDEADBEEF));
      advance();
      s_resp = 1'b0;

      // 2: continuous contention alternates m0,m1,...
      reset_cycle();
      we = 2'b00; addr[0] = 32'h100; addr[1] = 32'h200;
      for (int k = 0; k < 7; k++) begin
         req = (k < 6) ? 2'b11 : 2'b00;
         s_resp = (k > 0); s_rdata = 32'h1000 + k;
         check_cycle("t2");
         if (k < 6) chk("t2_grant", 72'({m0_ack, m1_ack}), 72'((k % 2 == 0) ? 2'b10 : 2'b01));
         if (k > 0) chk("t2_resp", 72'({m0_resp, m1_resp}), 72'(((k - 1) % 2 == 0) ? 2'b10 : 2'b01));
         advance();
      end
      s_resp = 1'b0;

      // 3: stalled m1 write keeps the grant while m0 joins
      req = 2'b10; we[1] = 1'b1; be[1] = 4'h1; addr[1] = 32'h300; wdata[1] = 32'hCAFE0001;
      s_ack = 1'b0;
      check_cycle("t3a");
      chk("t3_stall", 72'({s_req, m0_ack, m1_ack, s_be}), 72'({3'b100, 4'h1}));
      advance();
      req = 2'b11; we[0] = 1'b0; addr[0] = 32'h400; s_ack = 1'b1;
      check_cycle("t3b");
      chk("t3_hold", 72'({m0_ack, m1_ack, s_addr}), 72'({2'b01, 32'h300}));
      advance();
      req = 2'b01;
      check_cycle("t3c");
      chk("t3_next", 72'({m0_ack, m1_ack, s_addr}), 72'({2'b10, 32'h400}));
      advance();
      req = 2'b00; s_resp = 1'b1; s_rdata = 32'h3333;
      check_cycle("t3d");
      chk("t3_resp", 72'({m0_resp, m1_resp}), 72'(2'b10));
      advance();
      s_resp = 1'b0;

      // 4: full FIFO blocks reads but not writes; a response admits the read
      reset_cycle();
      req = 2'b01; we = 2'b10; addr[0] = 32'h500; addr[1] = 32'h600;
      check_cycle("t4a"); advance();
      check_cycle("t4b"); advance();
      check_cycle("t4c");
      chk("t4_block", 72'({s_req, m0_ack}), 72'(0));
      advance();
      req = 2'b11;
      check_cycle("t4d");
      chk("t4_write", 72'({m0_ack, m1_ack, s_we}), 72'(3'b011));
      advance();
      req = 2'b01; s_resp = 1'b1; s_rdata = 32'h4444;
      check_cycle("t4e");
      chk("t4_fullpop", 72'({m0_ack, m0_resp, m1_resp}), 72'(3'b110));
      advance();
      req = 2'b00; s_resp = 1'b0;
      check_cycle("t4f"); advance();

      // 6: reset with two reads outstanding drops later responses
      reset_cycle();
      for (int k = 0; k < 2; k++) begin
         s_resp = 1'b1; s_rdata = 32'h6000 + k;
         check_cycle("t6");
         chk("t6_drop", 72'({m0_resp, m1_resp}), 72'(0));
         advance();
      end

      // 5: stray response leaves the FIFO empty, so the next read routes correctly
      check_cycle("t5a");
      chk("t5_stray", 72'({m0_resp, m1_resp}), 72'(0));
      advance();
      s_resp = 1'b0; req = 2'b10; we = 2'b00; addr[1] = 32'h700;
      check_cycle("t5b"); advance();
      req = 2'b00; s_resp = 1'b1; s_rdata = 32'h5555;
      check_cycle("t5c");
      chk("t5_route", 72'({m0_resp, m1_resp}), 72'(2'b01));
      advance();
      s_resp = 1'b0;

      // random traffic; masters hold their request until the model says it was acked
      for (int c = 0; c < 3000; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 2) != 0) begin
               pend[m]  = 1'b1;
               we[m]    = 1'($urandom_range(0, 1));
               addr[m]  = $urandom;
               be[m]    = 4'($urandom);
               wdata[m] = $urandom;
            end
            req[m] = pend[m];
         end
         s_ack   = ($urandom_range(0, 3) != 0);
         s_resp  = ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            reset_cycle();
         end else begin
            check_cycle("rand");
            advance();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
